pg_sequencer: RTL and testbench

- Power-gating sequencer for the MIPS core power domain.
- Detects sustained idle, defined as consecutive ADDI-NOP opcodes (6'b001000).
- Powers the domain down in a fixed order: isolate, save retention, switch off. Powers it back up in the reverse order on a wake request.
- Sits in top beside the core. Drives the power-switch control, isolation enable, retention strobes and core stall; monitors the switch-chain acknowledge.

---
 rtl/pg_sequencer.sv | 71 +++++++
 tb/tb_pg_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pg_sequencer.sv
// pg_sequencer: power-gating sequencer that isolates, saves, switches off and restores the core domain
module pg_sequencer #(
    parameter int IDLE_THRESH = 10,
    parameter int ISO_SETUP   = 2,
    parameter int WAKE_SETTLE = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       wake_req,
    input  logic       force_on,
    input  logic       sw_ack,
    output logic       sw_off,
    output logic       iso_enable,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       cpu_stall,
    output logic       pd_on,
    output logic       err_timeout,
    output logic [2:0] state
);
    typedef enum logic [2:0] {ON, ISO, SAVE, PWR_DN, OFF, PWR_UP, SETTLE, RESTORE} state_t;
    localparam logic [5:0] NOP = 6'b001000;
    state_t cur, nxt;
    logic [4:0] idle_cnt;
    logic [7:0] timer;
    logic err_set;
    always_comb begin
        nxt = cur;
        err_set = 1'b0;
        case (cur)
            ON:      if (idle_cnt == 5'(IDLE_THRESH) && !force_on && !wake_req) nxt = ISO;
            ISO:     if (timer == 8'(ISO_SETUP - 1)) nxt = SAVE;
            SAVE:    nxt = PWR_DN;
            PWR_DN:  if (!sw_ack) nxt = OFF;
                     else if (timer == 8'(ACK_TIMEOUT - 1)) begin
                         nxt = PWR_UP;
                         err_set = 1'b1;
                     end
            OFF:     if (wake_req || force_on) nxt = PWR_UP;
            // the switch chain may still come up late, so a timeout only flags
            PWR_UP:  if (sw_ack) nxt = SETTLE;
                     else if (timer == 8'(ACK_TIMEOUT - 1)) err_set = 1'b1;
            SETTLE:  if (timer == 8'(WAKE_SETTLE - 1)) nxt = RESTORE;
            RESTORE: nxt = ON;
            default: nxt = ON;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= ON;
            idle_cnt <= '0;
            timer <= '0;
            err_timeout <= 1'b0;
        end else begin
            cur <= nxt;
            timer <= (nxt != cur) ? 8'd0 : timer + 8'd1;
            err_timeout <= err_timeout | err_set;
            idle_cnt <= (cur != ON || opcode != NOP) ? 5'd0 :
                        (idle_cnt == 5'(IDLE_THRESH)) ? idle_cnt : idle_cnt + 5'd1;
        end
    end
    assign state       = cur;
    assign sw_off      = cur == PWR_DN || cur == OFF;
    assign iso_enable  = cur != ON;
    assign ret_save    = cur == SAVE;
    assign ret_restore = cur == RESTORE;
    assign cpu_stall   = cur != ON;
    assign pd_on       = cur == ON;
endmodule

// File: tb/tb_pg_sequencer.sv
// tb_pg_sequencer: table-driven scoreboard bench for pg_sequencer with per-cycle ordering invariants
module tb_pg_sequencer;
    localparam logic [2:0] S_ON = 3'd0, S_ISO = 3'd1, S_SAVE = 3'd2, S_PDN = 3'd3,
                           S_OFF = 3'd4, S_PUP = 3'd5, S_SET = 3'd6, S_RST = 3'd7;
    localparam logic [5:0] NOP = 6'b001000, RT = 6'b000000;

    logic clk = 1'b0, reset = 1'b1, wake_req = 1'b0, force_on = 1'b0, sw_ack = 1'b1;
    logic [5:0] opcode = RT;
    logic sw_off, iso_enable, ret_save, ret_restore, cpu_stall, pd_on, err_timeout;
    logic [2:0] state;
    logic armed = 1'b0;
    int checks = 0, passes = 0;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       wk, fo, ack;
        logic [2:0] st;
        logic       err;
    } vec_t;
    vec_t tbl[$];
    vec_t exp_q[$];

    pg_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .wake_req(wake_req), .force_on(force_on),
        .sw_ack(sw_ack), .sw_off(sw_off), .iso_enable(iso_enable), .ret_save(ret_save),
        .ret_restore(ret_restore), .cpu_stall(cpu_stall), .pd_on(pd_on),
        .err_timeout(err_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // {sw_off, iso_enable, ret_save, ret_restore, cpu_stall, pd_on} for each state
    function automatic logic [5:0] outs_of(logic [2:0] st);
        return {st == S_PDN || st == S_OFF, st != S_ON, st == S_SAVE, st == S_RST, st != S_ON, st == S_ON};
    endfunction

    function automatic void add(int n, logic r, logic [5:0] op, logic wk, logic fo, logic ack,
                                logic [2:0] st, logic e);
        vec_t v;
        v = '{rst: r, op: op, wk: wk, fo: fo, ack: ack, st: st, err: e};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic step(vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst; opcode = v.op; wake_req = v.wk; force_on = v.fo; sw_ack = v.ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("state", 8'(state), 8'(e.st));
        chk("outputs", 8'({sw_off, iso_enable, ret_save, ret_restore, cpu_stall, pd_on}), 8'(outs_of(e.st)));
        chk("err_timeout", 8'(err_timeout), 8'(e.err));
        armed = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (armed) begin
            chk("inv_iso", 8'(!(sw_off || (!sw_ack && state != S_ON)) || iso_enable), 8'd1);
            chk("inv_save", 8'(!ret_save || (iso_enable && !sw_off)), 8'd1);
            chk("inv_restore", 8'(!ret_restore || (sw_ack && iso_enable)), 8'd1);
        end
    end

    initial begin
        // reset state
        add(2, 1, RT, 0, 0, 1, S_ON, 0);
        // 10 NOPs power down; sw_ack follows sw_off after 3 cycles; OFF ignores opcode and ack glitch
        add(10, 0, NOP, 0, 0, 1, S_ON, 0);
        add(2, 0, NOP, 0, 0, 1, S_ISO, 0);
        add(1, 0, NOP, 0, 0, 1, S_SAVE, 0);
        add(3, 0, NOP, 0, 0, 1, S_PDN, 0);
        add(3, 0, NOP, 0, 0, 0, S_OFF, 0);
        add(1, 0, RT, 0, 0, 1, S_OFF, 0);
        add(1, 0, NOP, 0, 0, 0, S_OFF, 0);
        // one-cycle wake pulse, ack 2 cycles after sw_off falls
        add(1, 0, RT, 1, 0, 0, S_PUP, 0);
        add(1, 0, RT, 0, 0, 0, S_PUP, 0);
        add(4, 0, RT, 0, 0, 1, S_SET, 0);
        add(1, 0, RT, 0, 0, 1, S_RST, 0);
        add(1, 0, RT, 0, 0, 1, S_ON, 0);
        // counter restarted on ON entry and cleared by a non-NOP; ack glitch in ON
        add(9, 0, NOP, 0, 0, 1, S_ON, 0);
        add(1, 0, RT, 0, 0, 1, S_ON, 0);
        add(8, 0, NOP, 0, 0, 1, S_ON, 0);
        add(1, 0, NOP, 0, 0, 0, S_ON, 0);
        add(1, 0, RT, 0, 0, 1, S_ON, 0);
        // force_on blocks entry; dropping it enters ISO at once; wake in ISO/SAVE does not abort
        add(20, 0, NOP, 0, 1, 1, S_ON, 0);
        add(1, 0, NOP, 0, 0, 1, S_ISO, 0);
        add(1, 0, NOP, 1, 0, 1, S_ISO, 0);
        add(1, 0, NOP, 1, 0, 1, S_SAVE, 0);
        // ack stuck high in PWR_DN: timeout after 16 cycles, abort to PWR_UP
        add(16, 0, NOP, 0, 0, 1, S_PDN, 0);
        add(1, 0, NOP, 0, 0, 1, S_PUP, 1);
        add(4, 0, RT, 0, 0, 1, S_SET, 1);
        add(1, 0, RT, 0, 0, 1, S_RST, 1);
        add(3, 0, RT, 0, 0, 1, S_ON, 1);
        // clear, then PWR_UP timeout keeps waiting for the ack
        add(1, 1, RT, 0, 0, 1, S_ON, 0);
        add(10, 0, NOP, 0, 0, 1, S_ON, 0);
        add(2, 0, NOP, 0, 0, 1, S_ISO, 0);
        add(1, 0, NOP, 0, 0, 1, S_SAVE, 0);
        add(1, 0, NOP, 0, 0, 1, S_PDN, 0);
        add(1, 0, NOP, 0, 0, 0, S_OFF, 0);
        add(1, 0, NOP, 1, 0, 0, S_PUP, 0);
        add(15, 0, NOP, 0, 0, 0, S_PUP, 0);
        add(2, 0, NOP, 0, 0, 0, S_PUP, 1);
        add(4, 0, RT, 0, 0, 1, S_SET, 1);
        add(1, 0, RT, 0, 0, 1, S_RST, 1);
        add(1, 0, RT, 0, 0, 1, S_ON, 1);
        // wake held through the descent: OFF lasts exactly one cycle
        add(10, 0, NOP, 0, 0, 1, S_ON, 1);
        add(1, 0, NOP, 0, 0, 1, S_ISO, 1);
        add(1, 0, NOP, 1, 0, 1, S_ISO, 1);
        add(1, 0, NOP, 1, 0, 1, S_SAVE, 1);
        add(1, 0, NOP, 1, 0, 1, S_PDN, 1);
        add(1, 0, NOP, 1, 0, 0, S_OFF, 1);
        add(1, 0, NOP, 1, 0, 0, S_PUP, 1);
        add(4, 0, RT, 0, 0, 1, S_SET, 1);
        add(1, 0, RT, 0, 0, 1, S_RST, 1);
        add(1, 0, RT, 0, 0, 1, S_ON, 1);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // reset asserted while OFF returns ON outputs and clears the sticky error
        for (int i = 0; i < 10; i++) step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 1, st: S_ON, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 1, st: S_ISO, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 1, st: S_ISO, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 1, st: S_SAVE, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 1, st: S_PDN, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 0, st: S_OFF, err: 1});
        step('{rst: 0, op: NOP, wk: 0, fo: 0, ack: 0, st: S_OFF, err: 1});
        step('{rst: 1, op: NOP, wk: 0, fo: 0, ack: 1, st: S_ON, err: 0});
        step('{rst: 0, op: RT, wk: 0, fo: 0, ack: 1, st: S_ON, err: 0});

        @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
